// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Bundle of the instruction-memory bus, the decode handshake
//                and the redirect/fault sideband of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_if;
    // Instruction memory side
    logic [31:0] iaddr;
    logic [31:0] idata;
    // Decode handshake
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    // Control-flow redirect and fault report
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    // Fetch-unit view
    modport master (
        output iaddr,
        input  idata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        input  redirect,
        input  redirect_pc,
        output fault,
        output fault_pc
    );

    // Environment view (memory, decode, branch resolution)
    modport slave (
        input  iaddr,
        output idata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        output redirect,
        output redirect_pc,
        input  fault,
        input  fault_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Program counter plus instruction fetch. Drives imem with the
//                PC, captures the returned word in the same cycle and queues
//                {word, pc} pairs for decode behind a valid/ready handshake.
//                Redirects flush the queue; misaligned targets park the unit
//                in a fault state until an aligned redirect arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  wire        clk,
    input  wire        rst,
    fetch_if.master    bus
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(QDEPTH);
    localparam logic [0:0]       c_st_fetch = 1'b0;
    localparam logic [0:0]       c_st_fault = 1'b1;

    // Architectural state
    logic [31:0]      pc_q,       pc_d;
    logic [0:0]       state_q,    state_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [PTR_W-1:0] head_q,     head_d;
    logic [PTR_W-1:0] tail_q,     tail_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [31:0]      data_q [QDEPTH];
    logic [31:0]      data_d [QDEPTH];
    logic [31:0]      epc_q  [QDEPTH];
    logic [31:0]      epc_d  [QDEPTH];

    logic w_pop;
    logic w_push;
    logic w_aligned;

    // Handshake qualifiers; a redirect suppresses both queue operations
    always_comb begin
        w_aligned = (bus.redirect_pc[1:0] == 2'b00);
        w_pop     = (count_q != '0) && bus.inst_ready && !bus.redirect;
        w_push    = (state_q == c_st_fetch) && !bus.redirect &&
                    ((count_q != c_depth) || w_pop);
    end

    // Next-state computation for PC, FSM, fault capture and the queue
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        fault_pc_d = fault_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        data_d     = data_q;
        epc_d      = epc_q;

        if (bus.redirect) begin
            // Flush; pointers restart at zero so the queue is trivially empty
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (w_aligned) begin
                pc_d    = bus.redirect_pc;
                state_d = c_st_fetch;
            end else begin
                // PC is left untouched; only the offending target is recorded
                state_d    = c_st_fault;
                fault_pc_d = bus.redirect_pc;
            end
        end else begin
            if (w_pop) begin
                head_d = head_q + 1'b1;
            end
            if (w_push) begin
                data_d[tail_q] = bus.idata;
                epc_d[tail_q]  = pc_q;
                tail_d         = tail_q + 1'b1;
                pc_d           = pc_q + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= c_st_fetch;
            fault_pc_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            fault_pc_q <= fault_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            data_q     <= data_d;
            epc_q      <= epc_d;
        end
    end

    // Outputs: address is the live PC, head entry drives decode
    always_comb begin
        bus.iaddr      = pc_q;
        bus.inst_valid = (count_q != '0);
        bus.inst       = data_q[head_q];
        bus.inst_pc    = epc_q[head_q];
        bus.fault      = (state_q == c_st_fault);
        bus.fault_pc   = fault_pc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A queue-based model of
//                the fetch stage tracks expected outputs every cycle; directed
//                steps pin the model with literal values, then random traffic
//                exercises back-pressure, redirects, faults and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fetch_if bus();
    fetch_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    // Instruction memory image: word k holds 0x1000_0000 + k
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.idata        = mem_word(bus.iaddr);
    assign bus2.idata       = mem_word(bus2.iaddr);
    assign bus2.inst_ready  = 1'b1;
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mq[$];     // {word, pc}, front is the head
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fpc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_fpc   = 32'h0;
        end else if (bus.redirect) begin
            mq.delete();
            if (bus.redirect_pc[1:0] == 2'b00) begin
                m_pc    = bus.redirect_pc;
                m_fault = 1'b0;
            end else begin
                m_fault = 1'b1;
                m_fpc   = bus.redirect_pc;
            end
        end else begin
            bit pop, push;
            pop  = (mq.size() > 0) && bus.inst_ready;
            push = !m_fault && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mem_word(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("iaddr", bus.iaddr, m_pc);
            chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("inst", bus.inst, mq[0][63:32]);
                chk("inst_pc", bus.inst_pc, mq[0][31:0]);
            end
            chk("fault", {31'b0, bus.fault}, {31'b0, m_fault});
            if (m_fault) chk("fault_pc", bus.fault_pc, m_fpc);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_valid",    {31'b0, bus.inst_valid}, 32'h0);
        chk("rst_inst",     bus.inst,     32'h0);
        chk("rst_inst_pc",  bus.inst_pc,  32'h0);
        chk("rst_fault",    {31'b0, bus.fault}, 32'h0);
        chk("rst_fault_pc", bus.fault_pc, 32'h0);
        chk("rst_iaddr",    bus.iaddr,    32'h0);
        rst  = 1'b0;
        rst2 = 1'b0;

        // Streaming from reset, with the wrap-around instance alongside
        @(negedge clk);
        chk("s0_valid", {31'b0, bus.inst_valid}, 32'h1);
        chk("s0_inst",  bus.inst,    32'h1000_0000);
        chk("s0_pc",    bus.inst_pc, 32'h0);
        chk("s0_iaddr", bus.iaddr,   32'h4);
        chk("w0_pc",    bus2.inst_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("s1_inst",  bus.inst,    32'h1000_0001);
        chk("s1_pc",    bus.inst_pc, 32'h4);
        chk("s1_iaddr", bus.iaddr,   32'h8);
        chk("w1_pc",    bus2.inst_pc, 32'hFFFF_FFFC);

        // Back-pressure: queue fills, PC freezes, head holds
        bus.inst_ready = 1'b0;
        @(negedge clk);
        chk("w2_pc",    bus2.inst_pc, 32'h0000_0000);
        chk("w2_inst",  bus2.inst,    32'h1000_0000);
        repeat (4) @(negedge clk);
        chk("bp_iaddr", bus.iaddr,   32'hC);
        chk("bp_pc",    bus.inst_pc, 32'h4);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_pc", bus.inst_pc, 32'h8);
        chk("bp_iaddr2",    bus.iaddr,   32'h10);

        // Redirect while full
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        @(negedge clk);
        chk("rd_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("rd_iaddr", bus.iaddr, 32'h40);
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("rd_pc",   bus.inst_pc, 32'h40);
        chk("rd_inst", bus.inst,    32'h1000_0010);

        // Misaligned redirect and recovery
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h42;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("ft_fault",    {31'b0, bus.fault}, 32'h1);
        chk("ft_fault_pc", bus.fault_pc, 32'h42);
        chk("ft_valid",    {31'b0, bus.inst_valid}, 32'h0);
        chk("ft_iaddr",    bus.iaddr, 32'h44);
        repeat (2) @(negedge clk);
        chk("ft_hold_iaddr", bus.iaddr, 32'h44);
        chk("ft_hold_valid", {31'b0, bus.inst_valid}, 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("fc_fault", {31'b0, bus.fault}, 32'h0);
        chk("fc_iaddr", bus.iaddr, 32'h80);
        @(negedge clk);
        chk("fc_pc", bus.inst_pc, 32'h80);

        // Random traffic checked by the model, with occasional async resets
        for (int c = 0; c < 3000; c++) begin
            bus.inst_ready = ($urandom_range(0, 9) < 7);
            bus.redirect   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 4))
                0:       bus.redirect_pc = $urandom();
                1:       bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                default: bus.redirect_pc = {22'h0, $urandom_range(0, 255), 2'b00};
            endcase
            @(negedge clk);
            if ((c % 700) == 350) begin
                #2 rst = 1'b1;
                #1;
                chk("arst_valid", {31'b0, bus.inst_valid}, 32'h0);
                chk("arst_fault", {31'b0, bus.fault}, 32'h0);
                chk("arst_fpc",   bus.fault_pc, 32'h0);
                chk("arst_iaddr", bus.iaddr, 32'h0);
                #2 rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
